ps2_rx_controller: RTL and testbench

Sequences the PS/2 keyboard receive path inside the `clk` domain and emits one key event per make or break code. It oversamples the keyboard clock and data pins, frames each 11-bit PS/2 packet with a state machine, and applies a timeout and an optional parity check. It folds the `E0` (extended) and `F0` (break) prefixes into flags, then buffers finished events in a small FIFO with a valid/ready handshake. It sits between the keyboard pins and the scancode-to-ASCII translation and text-buffer logic.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/key_event_fifo.sv | 62 ++++++
 rtl/ps2_rx_controller.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_rx_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 receive path: frame FSM states, prefix byte codes
// and the event record carried through the key event FIFO.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_event_t;

   // PS/2 uses odd parity over the 8 data bits plus the parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small power-of-two FIFO of key events; a push while full is only performed
// when a pop happens in the same cycle.
module key_event_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  key_event_t push_data,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output key_event_t head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   key_event_t        mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              do_push, do_pop;

   always_comb begin
      full    = (count_q == (AW+1)'(DEPTH));
      empty   = (count_q == '0);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      head    = mem_q[rd_ptr_q];

      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard receiver: pin synchronisers, 11-bit frame FSM with timeout,
// E0/F0 prefix folding and an event FIFO. Optional macro PS2_PARITY_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | latching the parity bit
// STOP   | checking stop bit (and parity), accepting or discarding the byte
module ps2_rx_controller
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       PS2_KBCLK,
   input  logic       PS2_KBDAT,
   output logic       key_valid,
   input  logic       key_ready,
   output logic [7:0] key_code,
   output logic       key_break,
   output logic       key_ext,
   output logic       frame_err,
   output logic       overflow
);

   localparam int              TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]  kbclk_q, kbclk_d;
   logic [1:0]  kbdat_q, kbdat_d;
   logic        strobe;
   logic        dat_s;

   ps2_state_e  state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic        tmo_hit;
   logic        parity_ok;
   logic        byte_ok;
   logic        err;

   logic        ext_q, ext_d;
   logic        brk_q, brk_d;
   logic        frame_err_q, frame_err_d;
   logic        overflow_q, overflow_d;

   logic        push;
   key_event_t  push_ev;
   logic        pop;
   logic        fifo_full, fifo_empty;
   key_event_t  head;

   // Clock sync resets low so only a genuine high-to-low transition strobes.
   always_comb begin
      kbclk_d = {kbclk_q[1:0], PS2_KBCLK};
      kbdat_d = {kbdat_q[0], PS2_KBDAT};
      strobe  = !kbclk_q[1] && kbclk_q[2];
      dat_s   = kbdat_q[1];
   end

   always_comb begin
`ifdef PS2_PARITY_CHECK_EN
      parity_ok = odd_parity_ok(shift_q, parity_q);
`else
      parity_ok = 1'b1;
`endif
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      byte_ok   = 1'b0;
      err       = 1'b0;

      tmo_hit = (state_q != IDLE) && (tmo_q == TMO_LAST);

      if (state_q == IDLE || strobe || tmo_hit) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end

      // A strobe landing in the timeout cycle is deliberately dropped.
      if (tmo_hit) begin
         state_d = IDLE;
         err     = 1'b1;
      end else if (strobe) begin
         case (state_q)
            IDLE: begin
               if (!dat_s) begin
                  bit_cnt_d = '0;
                  state_d   = DATA;
               end
            end
            DATA: begin
               shift_d   = {dat_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               parity_d = dat_s;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (dat_s && parity_ok) begin
                  byte_ok = 1'b1;
               end else begin
                  err = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      ext_d   = ext_q;
      brk_d   = brk_q;
      push    = 1'b0;
      push_ev = '{ext: ext_q, brk: brk_q, code: shift_q};

      if (err) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (byte_ok) begin
         case (shift_q)
            PS2_EXT_CODE:   ext_d = 1'b1;
            PS2_BREAK_CODE: brk_d = 1'b1;
            default: begin
               push  = 1'b1;
               ext_d = 1'b0;
               brk_d = 1'b0;
            end
         endcase
      end

      pop         = key_valid && key_ready;
      frame_err_d = err;
      overflow_d  = push && fifo_full && !pop;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         kbclk_q     <= '0;
         kbdat_q     <= 2'b11;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         tmo_q       <= '0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         kbclk_q     <= kbclk_d;
         kbdat_q     <= kbdat_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tmo_q       <= tmo_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   key_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (resetn),
      .push      (push),
      .push_data (push_ev),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   // Head is masked when empty so outputs read zero out of reset.
   always_comb begin
      key_valid = !fifo_empty;
      key_code  = key_valid ? head.code : 8'h00;
      key_break = key_valid && head.brk;
      key_ext   = key_valid && head.ext;
      frame_err = frame_err_q;
      overflow  = overflow_q;
   end

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Bench for ps2_rx_controller: directed frames plus random traffic checked
// against a queue-based model of the prefix folding and event FIFO.
module tb_ps2_rx_controller;

   localparam int TMO   = 400;
   localparam int DEPTH = 4;
   localparam int HALF  = 8;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       kbclk = 1'b1;
   logic       kbdat = 1'b1;
   logic       ready_man = 1'b0;
   logic       rand_ready = 1'b0;
   logic       rr = 1'b0;
   logic       key_ready;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_break;
   logic       key_ext;
   logic       frame_err;
   logic       overflow;

   int errors = 0;
   int checks = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int exp_fe = 0;
   int exp_ov = 0;
   bit m_ext  = 1'b0;
   bit m_brk  = 1'b0;
   logic [9:0] exp_q[$];
   logic [9:0] head_exp;

   assign key_ready = rand_ready ? rr : ready_man;

   ps2_rx_controller #(
      .TIMEOUT_CYCLES (TMO),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .PS2_KBCLK (kbclk),
      .PS2_KBDAT (kbdat),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_code  (key_code),
      .key_break (key_break),
      .key_ext   (key_ext),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (resetn) begin
         if (frame_err) fe_cnt++;
         if (overflow)  ov_cnt++;
         if (key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_event_model_size", 32'(exp_q.size()), 1);
            end else begin
               head_exp = exp_q.pop_front();
               check_eq("event", 32'({key_ext, key_break, key_code}), 32'(head_exp));
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rr = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected outcome of one complete 11-bit frame.
   task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
      if (stop_bad || (PAR_EN && par_bad)) begin
         exp_fe++;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         if (exp_q.size() >= DEPTH) exp_ov++;
         else exp_q.push_back({m_ext, m_brk, b});
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                             input int nbits, input bit lat_chk);
      logic [10:0] bits;
      bits = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         kbdat = bits[i];
         wait_clks(HALF);
         if (i == 10) model_frame(b, par_bad, stop_bad);
         kbclk = 1'b0;
         if (lat_chk && i == 10) begin
            repeat (2) @(posedge clk);
            #1;
            check_eq("valid_after_edge2", 32'(key_valid), 0);
            @(posedge clk);
            #1;
            check_eq("valid_after_edge3", 32'(key_valid), 1);
            wait_clks(HALF - 3);
         end else begin
            wait_clks(HALF);
         end
         kbclk = 1'b1;
      end
      kbdat = 1'b1;
      wait_clks(HALF);
   endtask

   task automatic settle(input string tag);
      int n;
      n = 0;
      wait_clks(6);
      while (exp_q.size() != 0 && n < 300) begin
         wait_clks(1);
         n++;
      end
      wait_clks(2);
      check_eq({tag, "_drained"},   32'(exp_q.size()), 0);
      check_eq({tag, "_frame_err"}, 32'(fe_cnt), 32'(exp_fe));
      check_eq({tag, "_overflow"},  32'(ov_cnt), 32'(exp_ov));
   endtask

   initial begin
      logic [7:0] b;
      bit pb, sb;

      wait_clks(3);
      check_eq("reset_outputs",
               32'({key_valid, key_code, key_break, key_ext, frame_err, overflow}), 0);
      resetn = 1'b1;
      wait_clks(4);

      // Single make code, latency from stop edge, held head.
      ready_man = 1'b0;
      send_frame(8'h1C, 0, 0, 11, 1);
      check_eq("t1_code",  32'(key_code), 32'h1C);
      check_eq("t1_break", 32'(key_break), 0);
      check_eq("t1_ext",   32'(key_ext), 0);
      ready_man = 1'b1;
      settle("t1");

      send_frame(8'hF0, 0, 0, 11, 0);
      send_frame(8'h1C, 0, 0, 11, 0);
      settle("t2");

      send_frame(8'hE0, 0, 0, 11, 0);
      send_frame(8'hF0, 0, 0, 11, 0);
      send_frame(8'h75, 0, 0, 11, 0);
      send_frame(8'h1C, 0, 0, 11, 0);
      settle("t3");

      // Truncated frame after 5 data bits; timeout must also clear the pending break flag.
      send_frame(8'hF0, 0, 0, 11, 0);
      send_frame(8'hA5, 0, 0, 6, 0);
      exp_fe++;
      m_ext = 1'b0;
      m_brk = 1'b0;
      wait_clks(TMO + 20);
      check_eq("t4_timeout_err", 32'(fe_cnt), 32'(exp_fe));
      send_frame(8'h29, 0, 0, 11, 0);
      settle("t4");

      ready_man = 1'b0;
      send_frame(8'h16, 0, 0, 11, 0);
      send_frame(8'h1E, 0, 0, 11, 0);
      send_frame(8'h26, 0, 0, 11, 0);
      send_frame(8'h25, 0, 0, 11, 0);
      send_frame(8'h2E, 0, 0, 11, 0);
      wait_clks(6);
      check_eq("t5_overflow_once", 32'(ov_cnt), 1);
      check_eq("t5_valid_held",    32'(key_valid), 1);
      check_eq("t5_head_held",     32'(key_code), 32'h16);
      ready_man = 1'b1;
      settle("t5");

      send_frame(8'h29, 1, 0, 11, 0);
      settle("t6_parity");

      send_frame(8'h5A, 0, 1, 11, 0);
      send_frame(8'h5A, 0, 0, 11, 0);
      settle("t7_stop");

      // Reset in the middle of a frame, with a break prefix pending.
      send_frame(8'hF0, 0, 0, 11, 0);
      send_frame(8'h00, 0, 0, 4, 0);
      resetn = 1'b0;
      wait_clks(3);
      check_eq("t8_reset_outputs",
               32'({key_valid, key_code, key_break, key_ext, frame_err, overflow}), 0);
      m_ext = 1'b0;
      m_brk = 1'b0;
      resetn = 1'b1;
      wait_clks(4);
      send_frame(8'h1C, 0, 0, 11, 0);
      settle("t8");

      rand_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         b = 8'($urandom);
         case ($urandom_range(0, 5))
            0: b = 8'hE0;
            1: b = 8'hF0;
            default: ;
         endcase
         pb = ($urandom_range(0, 7) == 0);
         sb = ($urandom_range(0, 11) == 0);
         send_frame(b, pb, sb, 11, 0);
         wait_clks($urandom_range(0, 20));
      end
      rand_ready = 1'b0;
      ready_man  = 1'b1;
      settle("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
